// File: rtl/data_mem_stage.sv
// MIPS memory stage: sync data RAM plus ALU pass-through, results RD_LAT cycles after accept.
// Backpressure: ready_dm low while the clear engine zero-fills the RAM; unaccepted ops are dropped.
module data_mem_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter int CLR_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] dm_data,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_sel_ex,
  input  logic              clr_req,
  output logic              ready_dm,
  output logic [DATA_W-1:0] ans_dm,
  output logic              valid_dm,
  output logic              addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [CW-1:0]     clr_cnt;
  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [AW-1:0]     idx;
  logic              in_range;
  logic              accept;
  logic              is_load;
  logic              do_store;

  assign addr     = ans_ex[ADDR_W-1:0];
  assign in_range = ({1'b0, addr} < DEPTH_C);
  assign idx      = in_range ? addr[AW-1:0] : '0;
  assign accept   = valid_ex & ready_dm & ~reset;
  assign is_load  = mem_en_ex & ~mem_rw_ex;
  assign do_store = accept & mem_en_ex & mem_rw_ex & in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
      if (CLR_EN != 0) begin
        state    <= S_CLEAR;
        ready_dm <= 1'b0;
      end else begin
        state    <= S_RUN;
        ready_dm <= 1'b1;
      end
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr_cnt == LAST_C) begin
            state    <= S_RUN;
            ready_dm <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
          end
        end
        S_RUN: begin
          // The op presented alongside clr_req is still accepted this cycle.
          if (clr_req) begin
            state    <= S_CLEAR;
            ready_dm <= 1'b0;
            clr_cnt  <= '0;
          end
        end
        default: begin
          state    <= S_CLEAR;
          ready_dm <= 1'b0;
          clr_cnt  <= '0;
        end
      endcase
    end
  end

  // Clear and store never coincide: ready_dm is low throughout CLEAR.
  always_ff @(posedge clk) begin
    if (!reset && state == S_CLEAR)
      ram[clr_cnt[AW-1:0]] <= '0;
    else if (do_store)
      ram[idx] <= dm_data;
  end

  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (accept)
      rd_q <= ram[idx];
  end

  logic              v1;
  logic              sel1;
  logic              ld1;
  logic              err1;
  logic [DATA_W-1:0] ans1;
  logic [DATA_W-1:0] res1;

  // Stage-1 controls only load on accept, so the result mux holds between ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      sel1 <= 1'b0;
      ld1  <= 1'b0;
      err1 <= 1'b0;
      ans1 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        sel1 <= mem_sel_ex;
        ld1  <= is_load & in_range;
        err1 <= mem_en_ex & ~in_range;
        ans1 <= ans_ex;
      end
    end
  end

  assign res1 = sel1 ? (ld1 ? rd_q : '0) : ans1;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign ans_dm   = res1;
      assign valid_dm = v1;
      assign addr_err = err1;
    end else begin : g_lat2
      logic              v2;
      logic              err2;
      logic [DATA_W-1:0] ans2;

      always_ff @(posedge clk) begin
        if (reset) begin
          v2   <= 1'b0;
          err2 <= 1'b0;
          ans2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) begin
            ans2 <= res1;
            err2 <= err1;
          end
        end
      end

      assign ans_dm   = ans2;
      assign valid_dm = v2;
      assign addr_err = err2;
    end
  endgenerate

endmodule
